code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Boot-time controller that fills the processor's code memory from a byte stream, then starts execution.
- Input is a valid/ready byte interface, e.g. a UART receiver.
- Drives the datapath's code_w_en, code_addr_in, code_in and run inputs.
- Guarantees that code memory writes and run never overlap; no write ever occurs while run is high.

Parameters:
- ADDR_W, 9: code memory address width; maximum program length is 2^ADDR_W words.
- DATA_W, 16: instruction width, fixed at two bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_req  in  1  single-cycle pulse that starts or restarts a load.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- code_w_en  out  1  code memory write enable.
- code_addr_in  out  ADDR_W  code memory write address.
- code_in  out  DATA_W  code memory write data.
- run  out  1  processor run enable.
- busy  out  1  load in progress.
- err  out  1  load failed, sticky until the next load_req.
- err_cause  out  2  01 = bad length, 10 = bad checksum, 00 = none.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (asynchronous, while rst_n low):
  - state IDLE.
  - All outputs 0: code_w_en, code_addr_in, code_in, run, busy, err, err_cause, words_loaded, rx_ready.
  - Internal length, address, checksum and byte registers cleared.
- Frame format: LEN_HI, LEN_LO, then N words each sent high byte first, then one CHK byte.
  - N = {LEN_HI, LEN_LO}.
  - The frame is good when the XOR of every frame byte, CHK included, equals 0x00.
- Byte transfer: a byte is accepted on a rising edge with rx_valid & rx_ready.
  - rx_ready = 1 only in states LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK.
  - rx_valid may drop at any time; the FSM waits with no timeout.
- States:
  - IDLE: load_req goes to LEN_HI; clears err, err_cause, words_loaded, address and checksum; busy becomes 1.
  - LEN_HI: on accept, latch the byte, then go to LEN_LO.
  - LEN_LO: on accept, form N.
    - If N == 0 or N > 2^ADDR_W: go to ERROR with err_cause = 01.
    - Otherwise go to DATA_HI.
  - DATA_HI: on accept, latch the high byte, then go to DATA_LO.
  - DATA_LO: on accept, latch the low byte, then go to WRITE.
  - WRITE: exactly one cycle.
    - Outputs: code_w_en = 1, code_addr_in = current address, code_in = {hi, lo}, rx_ready = 0.
    - At the next edge, the address and words_loaded increment.
    - If words_loaded + 1 == N, go to CHK; otherwise go to DATA_HI.
  - CHK: on accept, fold CHK into the XOR.
    - Result 0x00: go to RUN.
    - Otherwise: go to ERROR with err_cause = 10.
  - RUN: run = 1, busy = 0; load_req goes to LEN_HI, and run drops the same edge.
  - ERROR: err = 1, busy = 0, run = 0; load_req goes to LEN_HI.
- Output timing:
  - busy = 1 in all states from LEN_HI through CHK inclusive.
  - code_w_en is asserted only in WRITE.
  - run is asserted only in RUN; code_w_en and run are never both high.
- Address arithmetic:
  - The address counter is ADDR_W bits and starts at 0.
  - When N = 2^ADDR_W, the final write is at address 2^ADDR_W − 1; the counter then wraps to 0, but no further write occurs.
  - words_loaded is ADDR_W+1 bits so it can reach 2^ADDR_W.
- load_req while busy is ignored.
- The checksum accumulates all accepted bytes, length bytes included.
- code_addr_in and code_in hold their last values outside WRITE; the consumer must qualify them with code_w_en.
- Reset mid-load: everything returns to IDLE immediately and any partially assembled word is discarded. Memory contents are not rolled back.

Test Plan:
- Nominal load:
  - Stimulus: load_req, then bytes 00 02 12 34 AB CD 42 with rx_valid held high.
  - Response: code_w_en pulses with addr 0 / 0x1234 and addr 1 / 0xABCD; words_loaded = 2; run = 1, err = 0, busy = 0 after the CHK edge.
- Bad checksum:
  - Stimulus: same frame with CHK = 0x43.
  - Response: both words written; err = 1, err_cause = 10, run stays 0; a new load_req clears err.
- Bad length:
  - Stimulus: LEN 00 00, and separately LEN 02 01.
  - Response: ERROR with err_cause = 01 right after the LEN_LO accept; code_w_en never asserted.
- Full memory:
  - Stimulus: N = 0x0200 with word i = i, valid checksum.
  - Response: 512 writes at addresses 0..511 with the final write at 511; words_loaded = 512; run = 1.
- Throttled stream plus restart:
  - Stimulus: rx_valid toggled randomly during the nominal frame; once in RUN, pulse load_req.
  - Response: identical writes and result to the nominal load; run drops on the load_req edge and busy = 1.
- Reset mid-load:
  - Stimulus: assert rst_n low during DATA_LO of word 1.
  - Response: all outputs 0 asynchronously, state IDLE; no write for word 1; a following load completes normally.

Source files
------------

// File: rtl/code_loader.sv
// code_loader: boot-time controller that fills code memory from a byte stream
// and then starts the processor.
//
// Frame: LEN_HI, LEN_LO, N words (high byte first), CHK.  The frame is good
// when the XOR of every frame byte, CHK included, is 0x00.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   load_req       single-cycle pulse that starts/restarts a load (ignored while busy)
//   rx_data/rx_valid/rx_ready   byte stream handshake (accept on valid & ready)
//   code_w_en, code_addr_in, code_in   code memory write port
//   run            processor run enable (never high together with code_w_en)
//   busy           load in progress
//   err, err_cause failed load (01 bad length, 10 bad checksum), sticky until load_req
//   words_loaded   words written in the current load
module code_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr_in,
  output logic [DATA_W-1:0] code_in,
  output logic              run,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned MAX_N = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [7:0]          r_len_hi;
  logic [LEN_W-1:0]    r_len;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_words;
  logic [7:0]          r_chk;
  logic [7:0]          r_hi;
  logic [ADDR_W-1:0]   r_code_addr;
  logic [DATA_W-1:0]   r_code_data;
  logic [1:0]          r_err_cause;

  logic                w_accept;
  logic                w_start;
  logic [LEN_W-1:0]    w_len;
  logic                w_len_bad;
  logic [ADDR_W:0]     w_words_inc;
  logic                w_last;
  logic [7:0]          w_chk_final;

  assign w_accept    = rx_valid & rx_ready;
  assign w_start     = load_req & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_ERROR));
  assign w_len       = {r_len_hi, rx_data};
  assign w_len_bad   = (w_len == '0) || (32'(w_len) > MAX_N);
  assign w_words_inc = r_words + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last      = (LEN_W'(w_words_inc) == r_len);
  assign w_chk_final = r_chk ^ rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: if (load_req) w_next = S_LEN_HI;
      S_LEN_HI:  if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO:  if (w_accept) w_next = w_len_bad ? S_ERROR : S_DATA_HI;
      S_DATA_HI: if (w_accept) w_next = S_DATA_LO;
      S_DATA_LO: if (w_accept) w_next = S_WRITE;
      S_WRITE:   w_next = w_last ? S_CHK : S_DATA_HI;
      S_CHK:     if (w_accept) w_next = (w_chk_final == 8'h00) ? S_RUN : S_ERROR;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    code_w_en = 1'b0;
    run       = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        code_w_en = 1'b1;
        busy      = 1'b1;
      end
      S_RUN:   run = 1'b1;
      S_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  // Write address/data are captured on the DATA_LO accept so they are valid
  // during WRITE and then hold until the next word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_hi    <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_words     <= '0;
      r_chk       <= '0;
      r_hi        <= '0;
      r_code_addr <= '0;
      r_code_data <= '0;
      r_err_cause <= '0;
    end else begin
      if (w_start) begin
        r_addr      <= '0;
        r_words     <= '0;
        r_chk       <= '0;
        r_err_cause <= '0;
      end
      if (w_accept) begin
        r_chk <= w_chk_final;
      end
      case (r_state)
        S_LEN_HI:  if (w_accept) r_len_hi <= rx_data;
        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len_bad) r_err_cause <= 2'b01;
          end
        end
        S_DATA_HI: if (w_accept) r_hi <= rx_data;
        S_DATA_LO: begin
          if (w_accept) begin
            r_code_data <= DATA_W'({r_hi, rx_data});
            r_code_addr <= r_addr;
          end
        end
        S_WRITE: begin
          // Address wraps to 0 after a full-memory load; w_last stops further writes.
          r_addr  <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          r_words <= w_words_inc;
        end
        S_CHK: if (w_accept && (w_chk_final != 8'h00)) r_err_cause <= 2'b10;
        default: ;
      endcase
    end
  end

  assign code_addr_in = r_code_addr;
  assign code_in      = r_code_data;
  assign err_cause    = r_err_cause;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_req = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        code_w_en;
  logic [8:0]  code_addr_in;
  logic [15:0] code_in;
  logic        run;
  logic        busy;
  logic        err;
  logic [1:0]  err_cause;
  logic [9:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  int overlaps = 0;

  code_loader #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .code_w_en(code_w_en), .code_addr_in(code_addr_in), .code_in(code_in),
    .run(run), .busy(busy), .err(err), .err_cause(err_cause),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) begin
    if (code_w_en) wq.push_back('{a: code_addr_in, d: code_in});
    if (code_w_en && run) overlaps++;
  end

  typedef struct {
    logic       ld;
    logic       vld;
    logic [7:0] d;
    logic [41:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [41:0] pack_out(logic rdy, logic wen, logic [8:0] a, logic [15:0] c,
                                           logic r, logic b, logic e, logic [1:0] ec, logic [9:0] w);
    return {rdy, wen, a, c, r, b, e, ec, w};
  endfunction

  function automatic void add(logic ld, logic vld, logic [7:0] d,
                              logic rdy, logic wen, logic [8:0] a, logic [15:0] c,
                              logic r, logic b, logic e, logic [1:0] ec, logic [9:0] w);
    vec_t v;
    v.ld = ld; v.vld = vld; v.d = d;
    v.exp = pack_out(rdy, wen, a, c, r, b, e, ec, w);
    vecs.push_back(v);
  endfunction

  function automatic logic [41:0] cur_out();
    return {rx_ready, code_w_en, code_addr_in, code_in, run, busy, err, err_cause, words_loaded};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    bit acc;
    int n;
    n = 0;
    rx_data = b;
    forever begin
      rx_valid = (thr && ($urandom_range(0, 1) == 0)) ? 1'b0 : 1'b1;
      acc = rx_valid && rx_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_byte_timeout byte=%0h actual=no_accept required=accept", b);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_nominal(input bit thr);
    send_byte(8'h00, thr); send_byte(8'h02, thr);
    send_byte(8'h12, thr); send_byte(8'h34, thr);
    send_byte(8'hAB, thr); send_byte(8'hCD, thr);
    send_byte(8'h42, thr);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_done"}, 64'(busy), 64'(0));
  endtask

  task automatic check_nominal_writes(input string name);
    chk({name, "_nwr"}, 64'(wq.size()), 64'(2));
    if (wq.size() == 2) begin
      chk({name, "_w0"}, {wq[0].a, wq[0].d}, {9'd0, 16'h1234});
      chk({name, "_w1"}, {wq[1].a, wq[1].d}, {9'd1, 16'hABCD});
    end
  endtask

  initial begin
    logic [7:0]  csum;
    logic [15:0] w;
    int bad;

    // Reset state, checked asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 64'(cur_out()), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ld vld data | rdy wen addr code run busy err cause words
    add(1,0,8'h00, 1,0,9'd0,16'h0000,0,1,0,2'd0,10'd0);  // IDLE -> LEN_HI
    add(0,1,8'h00, 1,0,9'd0,16'h0000,0,1,0,2'd0,10'd0);
    add(0,1,8'h02, 1,0,9'd0,16'h0000,0,1,0,2'd0,10'd0);
    add(0,1,8'h12, 1,0,9'd0,16'h0000,0,1,0,2'd0,10'd0);
    add(0,1,8'h34, 0,1,9'd0,16'h1234,0,1,0,2'd0,10'd0);  // WRITE word 0
    add(0,1,8'hAB, 1,0,9'd0,16'h1234,0,1,0,2'd0,10'd1);  // byte not taken in WRITE
    add(0,1,8'hAB, 1,0,9'd0,16'h1234,0,1,0,2'd0,10'd1);
    add(0,1,8'hCD, 0,1,9'd1,16'hABCD,0,1,0,2'd0,10'd1);  // WRITE word 1
    add(0,1,8'h42, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd2);  // CHK
    add(0,1,8'h42, 0,0,9'd1,16'hABCD,1,0,0,2'd0,10'd2);  // RUN
    add(0,0,8'h00, 0,0,9'd1,16'hABCD,1,0,0,2'd0,10'd2);
    // restart from RUN, bad checksum, load_req while busy ignored
    add(1,0,8'h00, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd0);
    add(1,1,8'h00, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd0);
    add(0,1,8'h02, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd0);
    add(1,1,8'h12, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd0);
    add(0,1,8'h34, 0,1,9'd0,16'h1234,0,1,0,2'd0,10'd0);
    add(0,1,8'hAB, 1,0,9'd0,16'h1234,0,1,0,2'd0,10'd1);
    add(0,1,8'hAB, 1,0,9'd0,16'h1234,0,1,0,2'd0,10'd1);
    add(0,1,8'hCD, 0,1,9'd1,16'hABCD,0,1,0,2'd0,10'd1);
    add(0,0,8'h00, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd2);  // CHK, valid low
    add(0,1,8'h43, 0,0,9'd1,16'hABCD,0,0,1,2'd2,10'd2);  // ERROR bad checksum
    add(0,0,8'h00, 0,0,9'd1,16'hABCD,0,0,1,2'd2,10'd2);
    // bad length 0x0000
    add(1,0,8'h00, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd0);  // load_req clears err
    add(0,1,8'h00, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd0);
    add(0,1,8'h00, 0,0,9'd1,16'hABCD,0,0,1,2'd1,10'd0);
    // bad length 0x0201
    add(1,0,8'h00, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd0);
    add(0,1,8'h02, 1,0,9'd1,16'hABCD,0,1,0,2'd0,10'd0);
    add(0,1,8'h01, 0,0,9'd1,16'hABCD,0,0,1,2'd1,10'd0);

    foreach (vecs[i]) begin
      load_req = vecs[i].ld;
      rx_valid = vecs[i].vld;
      rx_data  = vecs[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 64'(cur_out()), 64'(vecs[i].exp));
    end
    load_req = 1'b0;
    rx_valid = 1'b0;

    // Full memory: N = 0x0200, word i = i.
    wq.delete();
    csum = 8'h02 ^ 8'h00;
    pulse_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int unsigned i = 0; i < 512; i++) begin
      w = 16'(i);
      csum = csum ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
    end
    send_byte(csum, 1'b0);
    wait_done("full");
    chk("full_nwr", 64'(wq.size()), 64'(512));
    bad = 0;
    foreach (wq[i]) begin
      if (wq[i].a !== 9'(i) || wq[i].d !== 16'(i)) bad++;
    end
    chk("full_contents_bad", 64'(bad), 64'(0));
    if (wq.size() > 0) chk("full_last_addr", 64'(wq[wq.size()-1].a), 64'(511));
    chk("full_words", 64'(words_loaded), 64'(512));
    chk("full_run_err", {62'(0), run, err}, 64'(2'b10));

    // Restart from RUN, then throttled nominal frame.
    pulse_load();
    chk("restart_run_busy", {62'(0), run, busy}, 64'(2'b01));
    wq.delete();
    send_nominal(1'b1);
    wait_done("thr");
    check_nominal_writes("thr");
    chk("thr_result", {53'(0), run, err, busy, words_loaded}, {53'(0), 3'b100, 10'd2});

    // Reset while in DATA_LO of word 1.
    wq.delete();
    pulse_load();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    chk("pre_reset_state", {62'(0), rx_ready, busy}, 64'(2'b11));
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'(cur_out()), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset_nwr", 64'(wq.size()), 64'(1));
    wq.delete();
    pulse_load();
    send_nominal(1'b0);
    wait_done("after_reset");
    check_nominal_writes("after_reset");
    chk("after_reset_result", {61'(0), run, err, busy}, 64'(3'b100));

    chk("wen_run_overlap", 64'(overlaps), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
